// File: rtl/busrq_arbiter.sv
// BUSRQ/BUSAK responder: freezes the CPU on an idle enabled tick, grants the
// bus to the DMA, then enforces a CPU-owned guard window after each release.
module busrq_arbiter #(
    parameter int GUARD_CYCLES = 4,
    parameter int MAX_HOLD     = 1024,
    parameter int HOLD_W       = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_enable,
    output logic       cpu_clk_enable,
    input  logic       cpu_mreq_n,
    input  logic       cpu_iorq_n,
    input  logic       cpu_rd_n,
    input  logic       cpu_wr_n,
    input  logic       cpu_m1_n,
    input  logic       busrq_n,
    output logic       busak_n,
    input  logic       hog_clr,
    output logic       hog_flag,
    output logic [7:0] grant_count
);

    localparam int GW = (GUARD_CYCLES > 0) ? $clog2(GUARD_CYCLES + 1) : 1;
    localparam bit HOG_EN = (MAX_HOLD != 0);
    localparam logic [HOLD_W-1:0] HOG_AT =
        HOLD_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

    typedef enum logic [2:0] {
        CPU_OWNS,
        WAIT_IDLE,
        STALLED,
        GRANTED,
        RELEASE,
        GUARD
    } state_t;

    state_t state, state_d;

    logic              busrq_q;
    logic              stall, stall_d;
    logic              busak_d;
    logic [HOLD_W-1:0] hold_cnt;
    logic [GW-1:0]     guard_cnt;
    logic              cpu_idle;
    logic              hog_set;

    assign cpu_idle = cpu_mreq_n & cpu_iorq_n & cpu_rd_n & cpu_wr_n & cpu_m1_n;
    assign hog_set  = HOG_EN && (state == GRANTED) && (hold_cnt == HOG_AT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= CPU_OWNS;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        unique case (state)
            CPU_OWNS:  if (!busrq_q) state_d = WAIT_IDLE;
            WAIT_IDLE: begin
                if (busrq_q) begin
                    state_d = CPU_OWNS;
                end else if (clk_enable && cpu_idle) begin
                    state_d = STALLED;
                end
            end
            STALLED:   state_d = GRANTED;
            GRANTED:   if (busrq_q) state_d = RELEASE;
            RELEASE:   state_d = (GUARD_CYCLES == 0) ? CPU_OWNS : GUARD;
            GUARD: begin
                if (clk_enable && guard_cnt <= GW'(1)) state_d = CPU_OWNS;
            end
            default:   state_d = CPU_OWNS;
        endcase
    end

    // Next values of the registered handshake outputs.
    always_comb begin
        stall_d = stall;
        busak_d = busak_n;
        unique case (state)
            WAIT_IDLE: begin
                if (!busrq_q && clk_enable && cpu_idle) stall_d = 1'b1;
            end
            STALLED:   busak_d = 1'b0;
            GRANTED:   if (busrq_q) busak_d = 1'b1;
            RELEASE:   stall_d = 1'b0;
            default:   ;
        endcase
    end

    assign cpu_clk_enable = clk_enable & ~stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busrq_q     <= 1'b1;
            stall       <= 1'b0;
            busak_n     <= 1'b1;
            hog_flag    <= 1'b0;
            grant_count <= 8'd0;
            hold_cnt    <= '0;
            guard_cnt   <= '0;
        end else begin
            busrq_q <= busrq_n;
            stall   <= stall_d;
            busak_n <= busak_d;

            if (state == STALLED) begin
                hold_cnt <= '0;
                if (grant_count != 8'hFF) grant_count <= grant_count + 8'd1;
            end else if (state == GRANTED && hold_cnt != '1) begin
                hold_cnt <= hold_cnt + HOLD_W'(1);
            end

            if (state == RELEASE) begin
                guard_cnt <= GW'(GUARD_CYCLES);
            end else if (state == GUARD && clk_enable && guard_cnt != '0) begin
                guard_cnt <= guard_cnt - GW'(1);
            end

            // A clear arriving on the same clk as the set loses.
            if (hog_set) begin
                hog_flag <= 1'b1;
            end else if (hog_clr) begin
                hog_flag <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_busrq_arbiter.sv
// Self-checking bench for busrq_arbiter: randomized bus activity and enables,
// expected event times derived from the grant/guard/hog rules.
module tb_busrq_arbiter;

    localparam int GUARD = 4;
    localparam int HOLD  = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       clk_enable;
    logic       cpu_clk_enable;
    logic       cpu_mreq_n, cpu_iorq_n, cpu_rd_n, cpu_wr_n, cpu_m1_n;
    logic       busrq_n;
    logic       busak_n;
    logic       hog_clr;
    logic       hog_flag;
    logic [7:0] grant_count;

    int errors = 0;
    int checks = 0;
    int exp_gc = 0;

    busrq_arbiter #(
        .GUARD_CYCLES(GUARD),
        .MAX_HOLD    (HOLD),
        .HOLD_W      (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .clk_enable    (clk_enable),
        .cpu_clk_enable(cpu_clk_enable),
        .cpu_mreq_n    (cpu_mreq_n),
        .cpu_iorq_n    (cpu_iorq_n),
        .cpu_rd_n      (cpu_rd_n),
        .cpu_wr_n      (cpu_wr_n),
        .cpu_m1_n      (cpu_m1_n),
        .busrq_n       (busrq_n),
        .busak_n       (busak_n),
        .hog_clr       (hog_clr),
        .hog_flag      (hog_flag),
        .grant_count   (grant_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Busy bus = a random non-empty set of CPU strobes low.
    task automatic set_bus(input bit busy);
        logic [4:0] m;
        m = busy ? 5'($urandom_range(1, 31)) : 5'd0;
        {cpu_mreq_n, cpu_iorq_n, cpu_rd_n, cpu_wr_n, cpu_m1_n} = ~m;
    endtask

    task automatic release_bus();
        busrq_n    = 1'b1;
        clk_enable = 1'b1;
        set_bus(1'b0);
        repeat (10) step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clk_enable = 1'b1;
        busrq_n = 1'b1;
        hog_clr = 1'b0;
        set_bus(1'b0);
        repeat (3) step();
        checks++;
        if (busak_n !== 1'b1) begin
            errors++;
            $display("FAIL reset_busak: got %b want 1", busak_n);
        end
        checks++;
        if (hog_flag !== 1'b0) begin
            errors++;
            $display("FAIL reset_hog: got %b want 0", hog_flag);
        end
        checks++;
        if (grant_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_count: got %0d want 0", grant_count);
        end
        checks++;
        if (cpu_clk_enable !== 1'b1) begin
            errors++;
            $display("FAIL reset_cce_hi: got %b want 1", cpu_clk_enable);
        end
        clk_enable = 1'b0;
        #1;
        checks++;
        if (cpu_clk_enable !== 1'b0) begin
            errors++;
            $display("FAIL reset_cce_lo: got %b want 0", cpu_clk_enable);
        end
        clk_enable = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        step();
    endtask

    // Idle bus, enable every clk: stall 2 clks and busak 3 clks after sampling.
    task automatic test_basic_grant();
        bit es;
        bit eb;
        clk_enable = 1'b1;
        set_bus(1'b0);
        busrq_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            es = (i >= 2);
            eb = !(i >= 3);
            checks++;
            if (cpu_clk_enable !== !es || busak_n !== eb) begin
                errors++;
                $display("FAIL basic_grant clk%0d: cce=%b busak_n=%b want %b %b",
                         i, cpu_clk_enable, busak_n, !es, eb);
            end
        end
        if (exp_gc < 255) exp_gc++;
        checks++;
        if (grant_count !== 8'(exp_gc)) begin
            errors++;
            $display("FAIL basic_count: got %0d want %0d", grant_count, exp_gc);
        end
        release_bus();
    endtask

    // Grant lands on the first enabled idle clk at or after WAIT_IDLE.
    task automatic test_busy_wait();
        bit en[40];
        bit idl[40];
        int b;
        int e;
        bit es;
        bit eb;
        for (int it = 0; it < 6; it++) begin
            b = (it == 0) ? 5 : int'($urandom_range(0, 5));
            for (int i = 0; i < 40; i++) begin
                en[i]  = (it == 0) ? 1'b1 : 1'($urandom_range(0, 1));
                idl[i] = (i >= b) && (it == 0 || $urandom_range(0, 2) != 0);
            end
            en[30]  = 1'b1;
            idl[30] = 1'b1;
            e = -1;
            for (int i = 2; i < 40; i++) begin
                if (e < 0 && en[i] && idl[i]) e = i;
            end
            busrq_n = 1'b0;
            for (int i = 0; i <= e + 2; i++) begin
                clk_enable = en[i];
                set_bus(!idl[i]);
                step();
                es = (i >= e);
                eb = !(i >= e + 1);
                checks++;
                if (cpu_clk_enable !== (en[i] & !es) || busak_n !== eb) begin
                    errors++;
                    $display("FAIL busy_wait it%0d clk%0d: cce=%b busak_n=%b want %b %b",
                             it, i, cpu_clk_enable, busak_n, en[i] & !es, eb);
                end
            end
            if (exp_gc < 255) exp_gc++;
            checks++;
            if (grant_count !== 8'(exp_gc)) begin
                errors++;
                $display("FAIL busy_count: got %0d want %0d", grant_count, exp_gc);
            end
            release_bus();
        end
    endtask

    task automatic test_withdraw();
        for (int it = 0; it < 4; it++) begin
            for (int j = 0; j < 8; j++) begin
                busrq_n = !(j < 2);
                clk_enable = 1'($urandom_range(0, 1));
                set_bus(j < 5);
                step();
                checks++;
                if (busak_n !== 1'b1 || cpu_clk_enable !== clk_enable) begin
                    errors++;
                    $display("FAIL withdraw it%0d clk%0d: busak_n=%b cce=%b want 1 %b",
                             it, j, busak_n, cpu_clk_enable, clk_enable);
                end
            end
            checks++;
            if (grant_count !== 8'(exp_gc)) begin
                errors++;
                $display("FAIL withdraw_count: got %0d want %0d", grant_count, exp_gc);
            end
            busrq_n = 1'b0;
            clk_enable = 1'b1;
            set_bus(1'b0);
            for (int k = 0; k < 4; k++) begin
                step();
                checks++;
                if (cpu_clk_enable !== !(k >= 2)) begin
                    errors++;
                    $display("FAIL withdraw_regrant clk%0d: cce=%b want %b",
                             k, cpu_clk_enable, !(k >= 2));
                end
            end
            if (exp_gc < 255) exp_gc++;
            release_bus();
        end
    endtask

    // Release then immediate re-request: guard needs GUARD enabled ticks.
    task automatic test_guard();
        bit en[60];
        int g4;
        int e;
        int ticks;
        bit es;
        bit eb;
        for (int it = 0; it < 4; it++) begin
            for (int j = 0; j < 60; j++) begin
                en[j] = (it == 0) ? (j % 2 == 1) : 1'($urandom_range(0, 1));
                if (j % 5 == 0 && it != 0) en[j] = 1'b1;
            end
            busrq_n = 1'b0;
            clk_enable = 1'b1;
            set_bus(1'b0);
            repeat (4) step();
            if (exp_gc < 255) exp_gc++;
            ticks = 0;
            g4 = -1;
            for (int j = 3; j < 60; j++) begin
                if (g4 < 0 && en[j]) begin
                    ticks++;
                    if (ticks == GUARD) g4 = j;
                end
            end
            e = -1;
            for (int j = g4 + 2; j < 60; j++) begin
                if (e < 0 && en[j]) e = j;
            end
            for (int j = 0; j <= e + 2; j++) begin
                busrq_n = (j == 0);
                clk_enable = en[j];
                step();
                es = (j < 2) || (j >= e);
                eb = !(j == 0 || j >= e + 1);
                checks++;
                if (cpu_clk_enable !== (en[j] & !es) || busak_n !== eb) begin
                    errors++;
                    $display("FAIL guard it%0d clk%0d: cce=%b busak_n=%b want %b %b",
                             it, j, cpu_clk_enable, busak_n, en[j] & !es, eb);
                end
            end
            if (exp_gc < 255) exp_gc++;
            checks++;
            if (grant_count !== 8'(exp_gc)) begin
                errors++;
                $display("FAIL guard_count: got %0d want %0d", grant_count, exp_gc);
            end
            release_bus();
        end
    endtask

    task automatic test_hog();
        bit hm;
        hm = 1'b0;
        hog_clr = 1'b0;
        clk_enable = 1'b1;
        set_bus(1'b0);
        for (int j = 0; j < 32; j++) begin
            busrq_n = (j >= 24);
            step();
            if (j == 3 + HOLD) hm = 1'b1;
            checks++;
            if (hog_flag !== hm) begin
                errors++;
                $display("FAIL hog_set clk%0d: got %b want %b", j, hog_flag, hm);
            end
        end
        if (exp_gc < 255) exp_gc++;
        hog_clr = 1'b1;
        step();
        hog_clr = 1'b0;
        checks++;
        if (hog_flag !== 1'b0) begin
            errors++;
            $display("FAIL hog_clear: got %b want 0", hog_flag);
        end
        step();
        checks++;
        if (hog_flag !== 1'b0) begin
            errors++;
            $display("FAIL hog_stays_clear: got %b want 0", hog_flag);
        end
        hm = 1'b0;
        busrq_n = 1'b0;
        for (int j = 0; j < 26; j++) begin
            hog_clr = (j == 3 + HOLD) || ($urandom_range(0, 1) == 1);
            step();
            if (j == 3 + HOLD) hm = 1'b1;
            else if (hog_clr) hm = 1'b0;
            checks++;
            if (hog_flag !== hm) begin
                errors++;
                $display("FAIL hog_clr_race clk%0d: got %b want %b", j, hog_flag, hm);
            end
        end
        hog_clr = 1'b0;
        if (exp_gc < 255) exp_gc++;
        release_bus();
    endtask

    task automatic test_reset_mid_grant();
        busrq_n = 1'b0;
        clk_enable = 1'b1;
        set_bus(1'b0);
        repeat (22) step();
        checks++;
        if (busak_n !== 1'b0 || hog_flag !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: busak_n=%b hog=%b want 0 1", busak_n, hog_flag);
        end
        #2 rst = 1'b1;
        #1;
        exp_gc = 0;
        checks++;
        if (busak_n !== 1'b1) begin
            errors++;
            $display("FAIL async_busak: got %b want 1", busak_n);
        end
        checks++;
        if (cpu_clk_enable !== 1'b1) begin
            errors++;
            $display("FAIL async_cce: got %b want 1", cpu_clk_enable);
        end
        checks++;
        if (grant_count !== 8'd0 || hog_flag !== 1'b0) begin
            errors++;
            $display("FAIL async_count_hog: count=%0d hog=%b want 0 0",
                     grant_count, hog_flag);
        end
        busrq_n = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        step();
    endtask

    task automatic test_saturation();
        clk_enable = 1'b1;
        set_bus(1'b0);
        for (int n = 0; n < 256; n++) begin
            busrq_n = 1'b0;
            repeat (4) step();
            if (exp_gc < 255) exp_gc++;
            checks++;
            if (grant_count !== 8'(exp_gc)) begin
                errors++;
                $display("FAIL saturate grant%0d: got %0d want %0d",
                         n + 1, grant_count, exp_gc);
            end
            busrq_n = 1'b1;
            repeat (8) step();
        end
    endtask

    initial begin
        test_reset();
        test_basic_grant();
        test_busy_wait();
        test_withdraw();
        test_guard();
        test_hog();
        test_reset_mid_grant();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
